// File: rtl/ifetch_pkg.sv
// Shared types and constants for the byte-serial instruction fetch stage
// and the control decode that consumes its instructions.
package ifetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_OP,
    FETCH_LO,
    FETCH_HI,
    HOLD
  } ifetch_state_t;

  localparam logic [1:0] LEN1 = 2'd1;
  localparam logic [1:0] LEN2 = 2'd2;
  localparam logic [1:0] LEN3 = 2'd3;

  // Opcodes whose length does not follow the cc/bbb addressing-mode pattern
  localparam logic [7:0] BRK = 8'h00;
  localparam logic [7:0] JSR = 8'h20;
  localparam logic [7:0] RTI = 8'h40;
  localparam logic [7:0] RTS = 8'h60;

endpackage

// File: rtl/instr_len_decode.sv
// Combinational opcode-length decoder (1..3 bytes), shared with control's
// decode so both agree on instruction boundaries.
module instr_len_decode
  import ifetch_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [1:0] len
);

  logic [2:0] bbb;

  assign bbb = opcode[4:2];

  // Special opcodes first, then addressing-mode groups; cc[0] alone
  // separates 01/11 from 00/10.
  always_comb begin
    len = LEN2;
    if (opcode == BRK || opcode == RTI || opcode == RTS) begin
      len = LEN1;
    end else if (opcode == JSR) begin
      len = LEN3;
    end else if (bbb == 3'b011 || bbb == 3'b111) begin
      len = LEN3;
    end else if (bbb == 3'b110) begin
      len = opcode[0] ? LEN3 : LEN1;
    end else if (bbb == 3'b010) begin
      len = opcode[0] ? LEN2 : LEN1;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Byte-serial instruction fetch: opcode plus 0-2 operand bytes, handed to control
// over valid/ready. Optional one-byte prefetch in HOLD: define IFETCH_PREFETCH_EN.
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter int                ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RST_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [7:0]        ins_opcode,
  output logic [7:0]        ins_op_lo,
  output logic [7:0]        ins_op_hi,
  output logic [1:0]        ins_len,
  output logic [ADDR_W-1:0] ins_pc
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  ifetch_state_t     state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [7:0]        op_byte;
  logic              op_take;
  logic [1:0]        op_len;
  logic [ADDR_W-1:0] op_pc;
  logic [ADDR_W-1:0] op_next_pc;

  assign mem_addr = fetch_pc;

`ifdef IFETCH_PREFETCH_EN
  localparam logic HOLD_RD = 1'b1;

  logic       buf_full;
  logic [7:0] buf_data;
  logic       pf_take;

  // A buffered opcode was fetched from fetch_pc-1, and fetch_pc already points past it.
  assign pf_take    = mem_rd & mem_ready;
  assign op_byte    = buf_full ? buf_data : mem_rdata;
  assign op_take    = buf_full | mem_ready;
  assign op_pc      = buf_full ? fetch_pc - PC_ONE : fetch_pc;
  assign op_next_pc = buf_full ? fetch_pc : fetch_pc + PC_ONE;

  always_ff @(posedge clk) begin
    if (rst || pc_load) begin
      buf_full <= 1'b0;
      buf_data <= 8'h00;
    end else if (state == HOLD && !buf_full && pf_take) begin
      buf_full <= 1'b1;
      buf_data <= mem_rdata;
    end else if (state == FETCH_OP && buf_full) begin
      buf_full <= 1'b0;
    end
  end
`else
  localparam logic HOLD_RD = 1'b0;

  assign op_byte    = mem_rdata;
  assign op_take    = mem_ready;
  assign op_pc      = fetch_pc;
  assign op_next_pc = fetch_pc + PC_ONE;
`endif

  instr_len_decode u_len (
    .opcode (op_byte),
    .len    (op_len)
  );

  // Redirect outranks everything but reset, including a byte accepted this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fetch_pc   <= RST_PC;
      mem_rd     <= 1'b0;
      ins_valid  <= 1'b0;
      ins_opcode <= 8'h00;
      ins_op_lo  <= 8'h00;
      ins_op_hi  <= 8'h00;
      ins_len    <= 2'd0;
      ins_pc     <= '0;
    end else if (pc_load) begin
      state     <= FETCH_OP;
      fetch_pc  <= pc_in;
      mem_rd    <= 1'b1;
      ins_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_rd <= 1'b0;
        end
        FETCH_OP: begin
          if (op_take) begin
            ins_opcode <= op_byte;
            ins_len    <= op_len;
            ins_op_lo  <= 8'h00;
            ins_op_hi  <= 8'h00;
            ins_pc     <= op_pc;
            fetch_pc   <= op_next_pc;
            if (op_len == LEN1) begin
              state     <= HOLD;
              mem_rd    <= HOLD_RD;
              ins_valid <= 1'b1;
            end else begin
              state  <= FETCH_LO;
              mem_rd <= 1'b1;
            end
          end
        end
        FETCH_LO: begin
          if (mem_ready) begin
            ins_op_lo <= mem_rdata;
            fetch_pc  <= fetch_pc + PC_ONE;
            if (ins_len == LEN2) begin
              state     <= HOLD;
              mem_rd    <= HOLD_RD;
              ins_valid <= 1'b1;
            end else begin
              state <= FETCH_HI;
            end
          end
        end
        FETCH_HI: begin
          if (mem_ready) begin
            ins_op_hi <= mem_rdata;
            fetch_pc  <= fetch_pc + PC_ONE;
            state     <= HOLD;
            mem_rd    <= HOLD_RD;
            ins_valid <= 1'b1;
          end
        end
        HOLD: begin
`ifdef IFETCH_PREFETCH_EN
          if (!buf_full && pf_take) begin
            fetch_pc <= fetch_pc + PC_ONE;
            mem_rd   <= 1'b0;
          end
          if (ins_ready) begin
            state     <= FETCH_OP;
            ins_valid <= 1'b0;
            mem_rd    <= ~(buf_full | pf_take);
          end
`else
          if (ins_ready) begin
            state     <= FETCH_OP;
            ins_valid <= 1'b0;
            mem_rd    <= 1'b1;
          end
`endif
        end
        default: begin
          state  <= IDLE;
          mem_rd <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a byte-array memory model.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        pc_load;
  logic [15:0] pc_in;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        ins_valid;
  logic        ins_ready;
  logic [7:0]  ins_opcode;
  logic [7:0]  ins_op_lo;
  logic [7:0]  ins_op_hi;
  logic [1:0]  ins_len;
  logic [15:0] ins_pc;

  logic [7:0]  mem [0:65535];
  logic [15:0] rd_addr [0:255];
  int          total_reads;
  int          checks;
  int          errors;
  int          base;
  int          n;

  logic [7:0]  dec_op;
  logic [1:0]  dec_len;

  instr_fetch #(.ADDR_W(16), .RST_PC(16'h0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_load    (pc_load),
    .pc_in      (pc_in),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .ins_opcode (ins_opcode),
    .ins_op_lo  (ins_op_lo),
    .ins_op_hi  (ins_op_hi),
    .ins_len    (ins_len),
    .ins_pc     (ins_pc)
  );

  instr_len_decode u_dec (
    .opcode (dec_op),
    .len    (dec_len)
  );

  assign mem_rdata = mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every accepted bus read in a small ring buffer.
  always @(posedge clk) begin
    if (mem_rd && mem_ready) begin
      rd_addr[total_reads[7:0]] <= mem_addr;
      total_reads <= total_reads + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic load, input logic [15:0] pc);
    rst     = r;
    pc_load = load;
    pc_in   = pc;
    step();
    rst     = 1'b0;
    pc_load = 1'b0;
  endtask

  task automatic waitValid(output int cycles);
    cycles = 0;
    while (!ins_valid && cycles < 20) begin
      step();
      cycles++;
    end
    if (!ins_valid) checkOutput("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic checkIns(input string tag, input logic [7:0] op, input logic [7:0] lo,
                          input logic [7:0] hi, input logic [1:0] len, input logic [15:0] pc);
    checkOutput({tag, "_valid"}, ins_valid, 1'b1);
    checkOutput({tag, "_opcode"}, ins_opcode, op);
    checkOutput({tag, "_lo"}, ins_op_lo, lo);
    checkOutput({tag, "_hi"}, ins_op_hi, hi);
    checkOutput({tag, "_len"}, ins_len, len);
    checkOutput({tag, "_pc"}, ins_pc, pc);
  endtask

  task automatic checkDecode(input logic [7:0] op, input logic [1:0] len);
    dec_op = op;
    #1;
    checkOutput($sformatf("decode_%h", op), dec_len, len);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    total_reads = 0;
    rst         = 1'b0;
    pc_load     = 1'b0;
    pc_in       = 16'h0000;
    mem_ready   = 1'b1;
    ins_ready   = 1'b0;
    dec_op      = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

    step();
    applyStimulus(1'b1, 1'b0, 16'h0000);
    checkOutput("rst_valid", ins_valid, 1'b0);
    checkOutput("rst_rd", mem_rd, 1'b0);
    checkOutput("rst_addr", mem_addr, 16'h0000);
    checkOutput("rst_opcode", ins_opcode, 8'h00);
    checkOutput("rst_len", ins_len, 2'd0);
    checkOutput("rst_pc", ins_pc, 16'h0000);
    step();
    step();
    checkOutput("idle_no_autofetch", mem_rd, 1'b0);

    // Single-byte INX
    mem[16'h8000] = 8'hE8;
    applyStimulus(1'b0, 1'b1, 16'h8000);
    base = total_reads;
    checkOutput("t1_rd", mem_rd, 1'b1);
    checkOutput("t1_addr", mem_addr, 16'h8000);
    checkOutput("t1_valid_low", ins_valid, 1'b0);
    waitValid(n);
    checkOutput("t1_latency", n, 1);
    checkIns("t1", 8'hE8, 8'h00, 8'h00, 2'd1, 16'h8000);
    checkOutput("t1_reads", total_reads - base, 1);
    checkOutput("t1_read_addr", rd_addr[8'(base)], 16'h8000);
`ifndef IFETCH_PREFETCH_EN
    step();
    step();
    checkOutput("t1_hold_rd", mem_rd, 1'b0);
    checkOutput("t1_hold_reads", total_reads - base, 1);
    checkOutput("t1_hold_valid", ins_valid, 1'b1);
`endif

    // Back-to-back LDA #imm / STA abs
    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h42; mem[16'h8002] = 8'h8D;
    mem[16'h8003] = 8'h00; mem[16'h8004] = 8'h02;
    ins_ready = 1'b1;
    applyStimulus(1'b0, 1'b1, 16'h8000);
    waitValid(n);
    checkOutput("t2_latency1", n, 2);
    checkIns("t2a", 8'hA9, 8'h42, 8'h00, 2'd2, 16'h8000);
    step();
    checkOutput("t2_handshake", ins_valid, 1'b0);
    waitValid(n);
    checkOutput("t2_latency2", n, 3);
    checkIns("t2b", 8'h8D, 8'h00, 8'h02, 2'd3, 16'h8002);
    ins_ready = 1'b0;

    // Wait states during the low operand byte
    mem[16'h8000] = 8'hAD; mem[16'h8001] = 8'h34; mem[16'h8002] = 8'h12;
    applyStimulus(1'b0, 1'b1, 16'h8000);
    base = total_reads;
    step();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("t3_wait_addr", mem_addr, 16'h8001);
      checkOutput("t3_wait_rd", mem_rd, 1'b1);
    end
    mem_ready = 1'b1;
    waitValid(n);
    checkOutput("t3_latency", n, 2);
    checkIns("t3", 8'hAD, 8'h34, 8'h12, 2'd3, 16'h8000);
    checkOutput("t3_reads", total_reads - base, 3);
    checkOutput("t3_read1", rd_addr[8'(base + 1)], 16'h8001);

    // Redirect while FETCH_HI accepts a byte
    mem[16'hC000] = 8'hE8;
    applyStimulus(1'b0, 1'b1, 16'h8000);
    step();
    step();
    checkOutput("t4_hi_addr", mem_addr, 16'h8002);
    applyStimulus(1'b0, 1'b1, 16'hC000);
    checkOutput("t4_valid_low", ins_valid, 1'b0);
    checkOutput("t4_addr", mem_addr, 16'hC000);
    checkOutput("t4_rd", mem_rd, 1'b1);
    step();
    checkIns("t4", 8'hE8, 8'h00, 8'h00, 2'd1, 16'hC000);

    // JMP abs across the address wrap
    mem[16'hFFFE] = 8'h4C; mem[16'hFFFF] = 8'h00; mem[16'h0000] = 8'h80;
    applyStimulus(1'b0, 1'b1, 16'hFFFE);
    base = total_reads;
    waitValid(n);
    checkIns("t5", 8'h4C, 8'h00, 8'h80, 2'd3, 16'hFFFE);
    checkOutput("t5_reads", total_reads - base, 3);
    checkOutput("t5_read0", rd_addr[8'(base)], 16'hFFFE);
    checkOutput("t5_read1", rd_addr[8'(base + 1)], 16'hFFFF);
    checkOutput("t5_read2", rd_addr[8'(base + 2)], 16'h0000);
    checkOutput("t5_next_addr", mem_addr, 16'h0001);

    // Redirect in HOLD wins over a simultaneous handshake
    mem[16'h8000] = 8'hE8;
    ins_ready = 1'b1;
    applyStimulus(1'b0, 1'b1, 16'h8000);
    ins_ready = 1'b0;
    checkOutput("t6_valid_low", ins_valid, 1'b0);
    checkOutput("t6_addr", mem_addr, 16'h8000);
    step();
    checkIns("t6", 8'hE8, 8'h00, 8'h00, 2'd1, 16'h8000);

    // Reset outranks redirect
    applyStimulus(1'b1, 1'b1, 16'h1234);
    checkOutput("t7_rd", mem_rd, 1'b0);
    checkOutput("t7_addr", mem_addr, 16'h0000);
    checkOutput("t7_valid", ins_valid, 1'b0);
    checkOutput("t7_opcode", ins_opcode, 8'h00);

    checkDecode(8'h00, 2'd1);
    checkDecode(8'h20, 2'd3);
    checkDecode(8'h40, 2'd1);
    checkDecode(8'h60, 2'd1);
    checkDecode(8'hA9, 2'd2);
    checkDecode(8'h8D, 2'd3);
    checkDecode(8'hE8, 2'd1);
    checkDecode(8'h6C, 2'd3);
    checkDecode(8'h96, 2'd2);
    checkDecode(8'h1D, 2'd3);
    checkDecode(8'h19, 2'd3);
    checkDecode(8'h18, 2'd1);
    checkDecode(8'h1B, 2'd3);
    checkDecode(8'h0A, 2'd1);
    checkDecode(8'h0B, 2'd2);
    checkDecode(8'h84, 2'd2);

`ifdef IFETCH_PREFETCH_EN
    mem[16'h8000] = 8'hE8; mem[16'h8001] = 8'hE8;
    ins_ready = 1'b0;
    applyStimulus(1'b0, 1'b1, 16'h8000);
    base = total_reads;
    step();
    for (int i = 0; i < 5; i++) step();
    checkOutput("pf_reads", total_reads - base, 2);
    checkOutput("pf_read_addr", rd_addr[8'(base + 1)], 16'h8001);
    checkOutput("pf_hold_rd", mem_rd, 1'b0);
    ins_ready = 1'b1;
    step();
    ins_ready = 1'b0;
    checkOutput("pf_op_valid", ins_valid, 1'b0);
    checkOutput("pf_op_rd", mem_rd, 1'b0);
    step();
    checkIns("pf", 8'hE8, 8'h00, 8'h00, 2'd1, 16'h8001);
    checkOutput("pf_no_extra_read", total_reads - base, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
